uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
UART receive engine, the receive-side counterpart of the existing transmit path. It samples the asynchronous serial line rxd, which idles high, and frames 8N1 characters sent LSB first. Every bit is sampled at its mid-bit point using an internal bit-timing counter. Each completed character is presented as a one-cycle valid pulse to the core logic, with a stop-bit framing error flag.

Parameters:
CLK_DIV, 5208, clk cycles per bit (50 MHz / 9600 bps); legal range 4..8191.
DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rxd  input  1  serial line, asynchronous to clk, idle high
rx_data  output  DATA_BITS  last good character; LSB = first data bit received
rx_valid  output  1  one-cycle pulse; rx_data updated in the same cycle
frame_err  output  1  one-cycle pulse; stop bit was sampled low
parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without PARITY_EN
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, busy=0, state=IDLE, counter=0, synchronizer flops=1.
- Synchronizer: rxd passes through a 2-flop synchronizer, giving rxd_s. A third flop rxd_d holds the previous rxd_s. Falling edge: rxd_d=1 and rxd_s=0.
- Bit counter (13 bits):
  - Cleared to 0 while state == IDLE.
  - Otherwise increments each cycle and wraps to 0 after CLK_DIV-1.
  - Tick when counter == CLK_DIV/2-1 (integer division; 2603 by default).
- State machine IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: a falling edge moves to START; the counter starts from 0 on the next cycle.
  - START, on tick:
    - rxd_s=1 is a glitch/false start. Return to IDLE with no pulses.
    - rxd_s=0 moves to DATA with bit index 0.
  - DATA, on tick: shift rxd_s into the MSB of the shift register (right shift, so first bit ends in the LSB). After DATA_BITS ticks, move to STOP.
  - STOP, on tick, in all cases return to IDLE on the same edge so the next start edge is caught mid-stop-bit:
    - rxd_s=1: rx_data <= shift register and rx_valid=1 for the following cycle.
    - rxd_s=0: frame_err=1 for one cycle; rx_data is held unchanged.
- Latency: rx_valid rises one clk after the stop-bit mid-sample edge. That is about 9.5 bit times plus 3 cycles (2-flop synchronizer + edge flop) after the line falls.
- rx_valid, frame_err and parity_err are mutually exclusive and never asserted for two consecutive cycles.
- rxd changes mid-frame are ignored except at ticks; there is no resynchronization inside a frame.
- A falling edge in the same cycle as the STOP-to-IDLE transition is not detected. The next edge, or a line held low, is handled as follows: if the line is still low after the stop, a new frame starts only on a subsequent falling edge, so a break condition produces a single frame_err.
- A reset asserted mid-frame aborts immediately; after release the block waits for a fresh falling edge.
- No backpressure: rx_data is overwritten by the next good frame, and the consumer must capture it on rx_valid.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: an even-parity bit is expected between the last data bit and the stop bit, adding a PARITY state between DATA and STOP. At the parity tick, the XOR of the data bits and the parity bit must be 0.
- On a parity mismatch: parity_err pulses in the rx_valid slot, rx_valid is suppressed and rx_data is held. frame_err still has priority if the stop bit is low.
- Undefined: no PARITY state, and parity_err is constantly 0.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam defaults UART_CLK_DIV=5208 and UART_DATA_BITS=8
  - function mid_point(div) returning div/2-1
- Sub-module rx_bps_module: ports clk, rst_n, count_sig, bps_clk. It contains the counter and tick logic. uart_rx_core drives count_sig = (state != IDLE).

Test Plan (sim CLK_DIV=16, tick at count 7, 16 clk/bit):
- Send 0xA5 8N1, stop bit high -> one rx_valid pulse with rx_data=0xA5, frame_err=0, busy low after the stop mid-sample.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses with data 0x00 then 0xFF, 160 cycles apart (+/-1).
- Low glitch of 4 clk on idle line -> no pulses, busy high for 8-10 cycles then low, rx_data unchanged.
- Send 0x3C with the stop bit driven low, then idle -> frame_err single pulse, rx_valid=0, rx_data keeps its previous value.
- Assert rst_n low during data bit 3 of 0x81, release, then send 0x5A -> all outputs 0 during reset, then rx_valid with 0x5A only.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong, correct is 1) -> parity_err pulse, no rx_valid. With parity bit 1 -> rx_valid with rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types, defaults and helpers for the UART receive path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int UART_CLK_DIV   = 5208;
  localparam int UART_DATA_BITS = 8;

  // Counter value at which a bit is sampled (centre of the bit cell).
  function automatic int mid_point(input int div);
    return div / 2 - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_bps_module.sv
// ---------------------------------------------------------------------------
// rx_bps_module : bit-timing counter, emits bps_clk at each mid-bit point
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_bps_module
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_sig,
  output logic bps_clk
);

  localparam logic [12:0] CNT_LAST = 13'(CLK_DIV - 1);
  localparam logic [12:0] CNT_MID  = 13'(mid_point(CLK_DIV));

  logic [12:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 13'd0;
    end else if (!count_sig) begin
      cnt <= 13'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= 13'd0;
    end else begin
      cnt <= cnt + 13'd1;
    end
  end

  assign bps_clk = count_sig && (cnt == CNT_MID);

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core : 8N1 UART receiver, mid-bit sampling, frame/parity error pulses
// Optional even parity bit when UART_RX_PARITY_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = UART_CLK_DIV,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rxd_m;
  logic                 rxd_s;
  logic                 rxd_d;
  logic                 tick;
  logic                 fall;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall = rxd_d && !rxd_s;
  assign busy = (state != IDLE);

  rx_bps_module #(
    .CLK_DIV (CLK_DIV)
  ) u_bps (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_sig (busy),
    .bps_clk   (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_err_r;
  assign parity_err = par_err_r;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_idx   <= 3'd0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_err_r <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fall) state <= START;
        end
        START: begin
          if (tick) begin
            bit_idx <= 3'd0;
            state   <= rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_bad <= (^shreg) ^ rxd_s;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          // Leave on the mid-stop sample so a following start edge is not missed.
          if (tick) begin
            state <= IDLE;
            if (!rxd_s) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              par_err_r <= 1'b1;
`endif
            end else begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
